// File: rtl/ps2_kb_rx.sv
// PS/2 keyboard receiver: frames scancodes, tracks shift/break/extended
// prefixes, translates make codes to ASCII and queues them in a small FIFO.
module ps2_kb_rx #(
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic       mclk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_in,
  input  logic       KB_read_en,
  input  logic       KB_clear,
  output logic       KB_status,
  output logic [6:0] KB_data,
  output logic       KB_overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {IDLE, SHIFT} st_t;

  logic          ck_s1_q, ck_s2_q, ck_prev_q;
  logic          dt_s1_q, dt_s2_q;
  logic          fall;

  st_t           st_q, st_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    sr_q, sr_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_q, to_d;
  logic          shf_q, shf_d;
  logic          brk_q, brk_d;
  logic          ext_q, ext_d;
  logic          wr_q, wr_d;
  logic [6:0]    ch_q, ch_d;

  logic [AW-1:0] rp_q, rp_d;
  logic [AW-1:0] wp_q, wp_d;
  logic [AW:0]   fc_q, fc_d;
  logic          ovf_q, ovf_d;
  logic [6:0]    mem [FIFO_DEPTH];

  logic          frame_ok;
  logic          is_shift_code;
  logic          hit;
  logic [6:0]    lc;
  logic [6:0]    ascii;
  logic          empty, full, pop, do_wr;

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      ck_s1_q   <= 1'b1;
      ck_s2_q   <= 1'b1;
      ck_prev_q <= 1'b1;
      dt_s1_q   <= 1'b1;
      dt_s2_q   <= 1'b1;
    end else begin
      ck_s1_q   <= ps2_clk;
      ck_s2_q   <= ck_s1_q;
      ck_prev_q <= ck_s2_q;
      dt_s1_q   <= ps2_in;
      dt_s2_q   <= dt_s1_q;
    end
  end

  assign fall = ck_prev_q & ~ck_s2_q;

  // Odd parity over data+parity, stop bit is the bit sampled now
  assign frame_ok = (^{sr_q, par_q}) & dt_s2_q;
  assign is_shift_code = (sr_q == 8'h12) || (sr_q == 8'h59);

  always_comb begin
    hit = 1'b1;
    lc  = 7'h00;
    unique case (sr_q)
      8'h1C: lc = 7'h61;
      8'h32: lc = 7'h62;
      8'h21: lc = 7'h63;
      8'h23: lc = 7'h64;
      8'h24: lc = 7'h65;
      8'h2B: lc = 7'h66;
      8'h34: lc = 7'h67;
      8'h33: lc = 7'h68;
      8'h43: lc = 7'h69;
      8'h3B: lc = 7'h6A;
      8'h42: lc = 7'h6B;
      8'h4B: lc = 7'h6C;
      8'h3A: lc = 7'h6D;
      8'h31: lc = 7'h6E;
      8'h44: lc = 7'h6F;
      8'h4D: lc = 7'h70;
      8'h15: lc = 7'h71;
      8'h2D: lc = 7'h72;
      8'h1B: lc = 7'h73;
      8'h2C: lc = 7'h74;
      8'h3C: lc = 7'h75;
      8'h2A: lc = 7'h76;
      8'h1D: lc = 7'h77;
      8'h22: lc = 7'h78;
      8'h35: lc = 7'h79;
      8'h1A: lc = 7'h7A;
      8'h45: lc = 7'h30;
      8'h16: lc = 7'h31;
      8'h1E: lc = 7'h32;
      8'h26: lc = 7'h33;
      8'h25: lc = 7'h34;
      8'h2E: lc = 7'h35;
      8'h36: lc = 7'h36;
      8'h3D: lc = 7'h37;
      8'h3E: lc = 7'h38;
      8'h46: lc = 7'h39;
      8'h29: lc = 7'h20;
      8'h5A: lc = 7'h0D;
      8'h66: lc = 7'h08;
      default: hit = 1'b0;
    endcase
    // Only letters change case
    if (shf_q && lc >= 7'h61 && lc <= 7'h7A) begin
      ascii = lc - 7'h20;
    end else begin
      ascii = lc;
    end
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    sr_d  = sr_q;
    par_d = par_q;
    to_d  = to_q;
    shf_d = shf_q;
    brk_d = brk_q;
    ext_d = ext_q;
    wr_d  = 1'b0;
    ch_d  = ch_q;
    unique case (st_q)
      IDLE: begin
        to_d = '0;
        if (fall && !dt_s2_q) begin
          st_d  = SHIFT;
          cnt_d = 4'd1;
        end
      end
      SHIFT: begin
        if (fall) begin
          to_d = '0;
          if (cnt_q <= 4'd8) begin
            sr_d  = {dt_s2_q, sr_q[7:1]};
            cnt_d = cnt_q + 4'd1;
          end else if (cnt_q == 4'd9) begin
            par_d = dt_s2_q;
            cnt_d = 4'd10;
          end else begin
            st_d  = IDLE;
            cnt_d = 4'd0;
            if (frame_ok) begin
              if (ext_q) begin
                ext_d = 1'b0;
                brk_d = 1'b0;
              end else if (sr_q == 8'hF0) begin
                brk_d = 1'b1;
              end else if (sr_q == 8'hE0) begin
                ext_d = 1'b1;
              end else if (brk_q) begin
                brk_d = 1'b0;
                if (is_shift_code) shf_d = 1'b0;
              end else if (is_shift_code) begin
                shf_d = 1'b1;
              end else if (hit) begin
                wr_d = 1'b1;
                ch_d = ascii;
              end
            end
          end
        end else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
          st_d  = IDLE;
          cnt_d = 4'd0;
          to_d  = '0;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      st_q  <= IDLE;
      cnt_q <= 4'd0;
      sr_q  <= 8'h00;
      par_q <= 1'b0;
      to_q  <= '0;
      shf_q <= 1'b0;
      brk_q <= 1'b0;
      ext_q <= 1'b0;
      wr_q  <= 1'b0;
      ch_q  <= 7'h00;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
      par_q <= par_d;
      to_q  <= to_d;
      shf_q <= shf_d;
      brk_q <= brk_d;
      ext_q <= ext_d;
      wr_q  <= wr_d;
      ch_q  <= ch_d;
    end
  end

  assign empty = (fc_q == '0);
  assign full  = (fc_q == (AW+1)'(FIFO_DEPTH));
  assign pop   = KB_read_en & ~empty;
  // A pop in the same cycle frees the slot for a write into a full FIFO
  assign do_wr = wr_q & (~full | pop);

  always_comb begin
    rp_d  = rp_q;
    wp_d  = wp_q;
    fc_d  = fc_q;
    ovf_d = ovf_q;
    if (KB_clear) begin
      rp_d  = '0;
      wp_d  = '0;
      fc_d  = '0;
      ovf_d = 1'b0;
    end else begin
      if (pop) rp_d = rp_q + AW'(1);
      if (do_wr) wp_d = wp_q + AW'(1);
      if (wr_q && !do_wr) ovf_d = 1'b1;
      if (do_wr && !pop) begin
        fc_d = fc_q + (AW+1)'(1);
      end else if (pop && !do_wr) begin
        fc_d = fc_q - (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      rp_q  <= '0;
      wp_q  <= '0;
      fc_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      rp_q  <= rp_d;
      wp_q  <= wp_d;
      fc_q  <= fc_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge mclk) begin
    if (do_wr && !KB_clear) mem[wp_q] <= ch_q;
  end

  assign KB_status   = ~empty;
  assign KB_data     = empty ? 7'h00 : mem[rp_q];
  assign KB_overflow = ovf_q;

endmodule

// File: tb/tb_ps2_kb_rx.sv
// Bench for ps2_kb_rx: directed PS/2 frames, expected characters queued
// and checked by an independent reader process.
module tb_ps2_kb_rx;

  localparam int TO = 200;
  localparam int HP = 20;

  logic       mclk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_in = 1'b1;
  logic       tb_rd = 1'b0;
  logic       mon_rd = 1'b0;
  logic       KB_clear = 1'b0;
  logic       KB_read_en;
  logic       KB_status;
  logic [6:0] KB_data;
  logic       KB_overflow;

  int         n_chk = 0;
  int         n_fail = 0;
  logic [6:0] exp_q [$];
  bit         auto_rd = 1'b1;

  assign KB_read_en = tb_rd | mon_rd;

  ps2_kb_rx #(.TIMEOUT_CYCLES(TO), .FIFO_DEPTH(8)) dut (
    .mclk(mclk),
    .reset(reset),
    .ps2_clk(ps2_clk),
    .ps2_in(ps2_in),
    .KB_read_en(KB_read_en),
    .KB_clear(KB_clear),
    .KB_status(KB_status),
    .KB_data(KB_data),
    .KB_overflow(KB_overflow)
  );

  always #5 mclk = ~mclk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge mclk);
  endtask

  task automatic send(input logic [7:0] code, input bit bad_par,
                      input bit bad_stop, input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (~^code) ^ bad_par, code, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_in = f[i];
      cyc(HP);
      ps2_clk = 1'b0;
      cyc(HP);
      ps2_clk = 1'b1;
    end
    ps2_in = 1'b1;
    cyc(HP);
  endtask

  task automatic frame(input logic [7:0] code);
    send(code, 1'b0, 1'b0, 11);
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || KB_status) && t < 3000) begin
      cyc(1);
      t++;
    end
    n_chk++;
    if (t >= 3000) begin
      n_fail++;
      $display("FAIL %s_drain_timeout: got %0d pending expected 0",
               nm, exp_q.size());
    end
  endtask

  // Reader: pops the FIFO head whenever it is presented
  initial begin
    forever begin
      @(negedge mclk);
      if (!reset && auto_rd && KB_status) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_entry: got 0x%0h expected none", KB_data);
        end else begin
          n_chk--;
          chk("kb_data", KB_data, exp_q.pop_front());
        end
        mon_rd = 1'b1;
        @(negedge mclk);
        mon_rd = 1'b0;
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    cyc(3);
    chk("rst_status", KB_status, 0);
    chk("rst_data", KB_data, 0);
    chk("rst_ovf", KB_overflow, 0);
    reset = 1'b0;
    cyc(5);

    exp_q.push_back(7'h68);
    frame(8'h33);
    drain("single");
    cyc(2);
    chk("single_status_after", KB_status, 0);
    chk("single_data_after", KB_data, 0);

    auto_rd = 1'b0;
    tb_rd = 1'b1;
    cyc(1);
    tb_rd = 1'b0;
    auto_rd = 1'b1;
    exp_q.push_back(7'h68);
    frame(8'h33);
    drain("empty_read");

    exp_q.push_back(7'h48);
    frame(8'h12);
    frame(8'h33);
    frame(8'hF0);
    frame(8'h33);
    frame(8'hF0);
    frame(8'h12);
    exp_q.push_back(7'h68);
    frame(8'h33);
    drain("shift");

    send(8'h33, 1'b1, 1'b0, 11);
    send(8'h33, 1'b0, 1'b1, 11);
    cyc(10);
    chk("bad_frame_status", KB_status, 0);

    exp_q.push_back(7'h30); frame(8'h45);
    exp_q.push_back(7'h20); frame(8'h29);
    exp_q.push_back(7'h0D); frame(8'h5A);
    exp_q.push_back(7'h08); frame(8'h66);
    frame(8'h05);
    frame(8'hE0);
    frame(8'h1C);
    exp_q.push_back(7'h61); frame(8'h1C);
    exp_q.push_back(7'h39); frame(8'h46);
    drain("table");

    auto_rd = 1'b0;
    for (int i = 0; i < 9; i++) frame(8'h1C);
    chk("ovf_set", KB_overflow, 1);
    chk("ovf_status", KB_status, 1);
    chk("ovf_head", KB_data, 7'h61);
    for (int i = 0; i < 8; i++) exp_q.push_back(7'h61);
    auto_rd = 1'b1;
    drain("ovf");
    chk("ovf_sticky", KB_overflow, 1);
    KB_clear = 1'b1;
    cyc(1);
    KB_clear = 1'b0;
    cyc(1);
    chk("ovf_cleared", KB_overflow, 0);

    auto_rd = 1'b0;
    frame(8'h1C);
    chk("pre_clear_status", KB_status, 1);
    KB_clear = 1'b1;
    cyc(1);
    KB_clear = 1'b0;
    cyc(1);
    chk("clear_status", KB_status, 0);
    chk("clear_data", KB_data, 0);
    auto_rd = 1'b1;

    send(8'h1C, 1'b0, 1'b0, 5);
    cyc(TO + 100);
    exp_q.push_back(7'h61);
    frame(8'h1C);
    drain("timeout");

    auto_rd = 1'b0;
    frame(8'h1C);
    chk("pre_reset_status", KB_status, 1);
    send(8'h33, 1'b0, 1'b0, 6);
    reset = 1'b1;
    cyc(2);
    chk("midrst_status", KB_status, 0);
    chk("midrst_data", KB_data, 0);
    chk("midrst_ovf", KB_overflow, 0);
    reset = 1'b0;
    cyc(5);
    auto_rd = 1'b1;
    exp_q.push_back(7'h68);
    frame(8'h33);
    drain("after_reset");

    cyc(5);
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_kb_rx.md
PS2_KB_RX -- requirements
Module: ps2_kb_rx

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 200000, giving the mclk cycles of ps2_clk inactivity that abort a partial frame.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, giving the character FIFO entries (power of 2).
REQ-003 SHALL have port mclk, input, 1 bit: the only clock, rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port ps2_clk, input, 1 bit: raw PS/2 clock, asynchronous, idles high.
REQ-006 SHALL have port ps2_in, input, 1 bit: raw PS/2 data, asynchronous, idles high.
REQ-007 SHALL have port KB_read_en, input, 1 bit: pops the FIFO head.
REQ-008 SHALL have port KB_clear, input, 1 bit: flushes the FIFO.
REQ-009 SHALL have port KB_status, output, 1 bit: FIFO non-empty.
REQ-010 SHALL have port KB_data, output, 7 bits: ASCII at the FIFO head, 0 when empty.
REQ-011 SHALL have port KB_overflow, output, 1 bit: sticky, set when a character is dropped because the FIFO is full.

Function
REQ-012 SHALL pass ps2_clk and ps2_in each through a 2-flop synchronizer before use.
REQ-013 SHALL detect a falling edge of synchronized ps2_clk as prev=1, cur=0, and SHALL sample synchronized ps2_in in that detect cycle.
REQ-014 SHALL use frame FSM states IDLE and SHIFT, with bit counter 0..10.
- IDLE: a sampled 0 (start bit) goes to SHIFT with count=1; a sampled 1 stays in IDLE.
REQ-015 SHALL, in SHIFT, handle bits as follows:
- bits 1-8: data, LSB first.
- bit 9: odd parity.
- bit 10: stop bit, must be 1.
- after bit 10, return to IDLE.
REQ-016 SHALL accept a frame only if the parity is odd over data+parity and stop=1; otherwise it SHALL discard the frame silently.
REQ-017 SHALL, while in SHIFT, return to IDLE and discard the partial frame after TIMEOUT_CYCLES consecutive cycles with no falling edge; the counter SHALL reload on every edge.
REQ-018 SHALL, for an accepted scancode 0xF0, set break_pending and emit no character.
REQ-019 SHALL, for an accepted scancode 0xE0, set ext_pending and emit no character.
REQ-020 SHALL, when a scancode arrives with ext_pending set, clear ext_pending and break_pending and discard that code.
REQ-021 SHALL, when a scancode arrives with break_pending set, clear break_pending, clear shift if the code is 0x12 or 0x59, and emit no character.
REQ-022 SHALL, for make code 0x12 or 0x59, set shift and emit no character.
REQ-023 SHALL translate other make codes through a fixed table:
- letters a-z: 0x1C=a ... 0x33=h ..., giving lowercase, or uppercase when shift=1.
- digits 0-9: 0x45,0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46.
- 0x29 -> 0x20, 0x5A -> 0x0D, 0x66 -> 0x08.
- unmapped codes are dropped.
REQ-024 SHALL meet this latency, with T as the detect cycle of the stop bit:
- translation is registered and the FIFO write occurs at T+1.
- KB_status=1 and KB_data are valid from T+2.
REQ-025 SHALL, on KB_read_en=1 with the FIFO non-empty, remove the head at the clock edge; KB_data SHALL show the next entry in the following cycle.
REQ-026 SHALL ignore KB_read_en=1 when the FIFO is empty, with no pointer change.
REQ-027 SHALL, on a write with the FIFO full, drop the character and set KB_overflow; when a pop coincides with that write, both SHALL occur and there is no overflow.
REQ-028 SHALL, on KB_clear=1, empty the FIFO and clear KB_overflow at the next edge.
- clear beats a simultaneous write or pop.
- shift, break and ext state are unaffected.
REQ-029 SHALL wrap the FIFO pointers modulo FIFO_DEPTH, with an occupancy count 0..FIFO_DEPTH.

Reset
REQ-030 SHALL, while reset=1, immediately force:
- synchronizers to 1, frame FSM to IDLE, counters to 0.
- shift, break_pending and ext_pending to 0.
- FIFO empty, KB_status=0, KB_data=0, KB_overflow=0.
REQ-031 SHALL, on reset asserted mid-frame, abort the frame; after release, the next start bit begins a fresh frame.

Verification
REQ-032 SHALL cover a single frame: 0x33, parity 1 -> KB_status=1, KB_data=0x68 ('h'); one KB_read_en -> KB_status=0, KB_data=0.
REQ-033 SHALL cover shift: frames 0x12, 0x33, 0xF0, 0x33, 0xF0, 0x12 -> exactly one entry 0x48 ('H'); a following 0x33 -> 0x68.
REQ-034 SHALL cover bad parity: frame 0x33 with parity 0, then stop=0 on a good frame -> no entry, KB_status stays 0.
REQ-035 SHALL cover overflow: nine 0x1C frames with no reads -> 8 entries of 0x61, KB_overflow=1; eight reads drain in order; KB_clear -> KB_overflow=0.
REQ-036 SHALL cover timeout: start + 4 bits, then ps2_clk idle > TIMEOUT_CYCLES, then a full 0x1C frame -> single entry 0x61.
REQ-037 SHALL cover reset mid-frame: reset pulse after bit 5 -> all outputs 0; the next full 0x33 frame -> 0x68.
